// File: rtl/pipeline_late_wb_pkg.sv
// Shared widths, default queue depth and the write-entry record used by the
// late-writeback block and its write queue.
package pipeline_late_wb_pkg;

  localparam int REG_AW         = 5;
  localparam int DATA_W         = 32;
  localparam int QDEPTH_DEFAULT = 4;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/pipeline_wb_queue.sv
// Circular write queue: up to two pushes (push0 before push1) and one pop per
// cycle. Exposes the head entry, the occupancy and per-entry rd/valid so the
// parent can match source registers against pending writes.
module pipeline_wb_queue
  import pipeline_late_wb_pkg::*;
#(
  parameter  int QDEPTH = QDEPTH_DEFAULT,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push0_valid,
  input  wb_entry_t                      push0_entry,
  input  logic                           push1_valid,
  input  wb_entry_t                      push1_entry,
  input  logic                           pop,
  output wb_entry_t                      head_entry,
  output logic [CW-1:0]                  count,
  output logic [QDEPTH-1:0]              entry_valid,
  output logic [QDEPTH-1:0][REG_AW-1:0]  entry_rd
);

  wb_entry_t         mem_q [QDEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     tail1;
  logic [CW-1:0]     count_q, count_d;
  logic [QDEPTH-1:0] vld_q, vld_d;
  logic              pop_eff;
  logic              push1_eff;

  // Pointer increment that wraps at QDEPTH (works for non-power-of-two depths).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for pointers, occupancy and per-slot valid bits; pop clears
  // the head slot before pushes set theirs, so a full-wrap reuse is correct.
  always_comb begin
    pop_eff   = pop && (count_q != '0);
    push1_eff = push0_valid && push1_valid;
    tail1     = ptr_inc(tail_q);
    head_d    = pop_eff ? ptr_inc(head_q) : head_q;
    tail_d    = tail_q;
    vld_d     = vld_q;
    if (pop_eff) begin
      vld_d[head_q] = 1'b0;
    end
    if (push0_valid) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail1;
    end
    if (push1_eff) begin
      vld_d[tail1] = 1'b1;
      tail_d       = ptr_inc(tail1);
    end
    count_d = count_q + CW'(push0_valid) + CW'(push1_eff) - CW'(pop_eff);
  end

  // Control state register; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Entry storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (push0_valid) begin
      mem_q[tail_q] <= push0_entry;
    end
    if (push1_eff) begin
      mem_q[tail1] <= push1_entry;
    end
  end

  assign head_entry  = mem_q[head_q];
  assign count       = count_q;
  assign entry_valid = vld_q;

  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi++) begin : g_entry_rd
      assign entry_rd[gi] = mem_q[gi].rd;
    end
  endgenerate

endmodule

// File: rtl/pipeline_late_wb.sv
// Late-writeback merge: a one-cycle-late ALU result and an early result share
// one register-file write port. Oldest-first ordering (queue, late, early);
// overflow goes to the write queue, and stall throttles upstream issue.
module pipeline_late_wb
  import pipeline_late_wb_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              late_issue_valid,
  input  logic [REG_AW-1:0] late_issue_rd,
  input  logic [DATA_W-1:0] late_result,
  input  logic              early_valid,
  input  logic [REG_AW-1:0] early_rd,
  input  logic [DATA_W-1:0] early_result,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic              stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic              lv_q;
  logic [REG_AW-1:0] lrd_q;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic                          q_push0_valid, q_push1_valid, q_pop;
  wb_entry_t                     q_push0_entry, q_push1_entry, q_head;
  logic [CW-1:0]                 q_count;
  logic [QDEPTH-1:0]             q_entry_valid;
  logic [QDEPTH-1:0][REG_AW-1:0] q_entry_rd;

  logic      late_raw, early_raw, accept, late_ok, early_ok;
  wb_entry_t late_e, early_e;
  logic [QDEPTH-1:0] qmatch_rs, qmatch_rt;

  pipeline_wb_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push0_valid (q_push0_valid),
    .push0_entry (q_push0_entry),
    .push1_valid (q_push1_valid),
    .push1_entry (q_push1_entry),
    .pop         (q_pop),
    .head_entry  (q_head),
    .count       (q_count),
    .entry_valid (q_entry_valid),
    .entry_rd    (q_entry_rd)
  );

  // Arrivals writing r0 are dropped outright; a full queue drops everything new.
  assign late_raw  = lv_q && (lrd_q != '0);
  assign early_raw = early_valid && (early_rd != '0);
  assign accept    = (q_count != CW'(QDEPTH));
  assign late_ok   = late_raw && accept;
  assign early_ok  = early_raw && accept;
  assign late_e    = '{rd: lrd_q, data: late_result};
  assign early_e   = '{rd: early_rd, data: early_result};

  // Pick the oldest candidate for the write port and queue the rest in age order.
  always_comb begin
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    q_pop         = 1'b0;
    q_push0_valid = 1'b0;
    q_push0_entry = '0;
    q_push1_valid = 1'b0;
    q_push1_entry = '0;
    if (q_count != '0) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = q_head.rd;
      rf_wdata_d = q_head.data;
      q_pop      = 1'b1;
      if (late_ok) begin
        q_push0_valid = 1'b1;
        q_push0_entry = late_e;
        q_push1_valid = early_ok;
        q_push1_entry = early_e;
      end else if (early_ok) begin
        q_push0_valid = 1'b1;
        q_push0_entry = early_e;
      end
    end else if (late_ok) begin
      rf_we_d       = 1'b1;
      rf_waddr_d    = lrd_q;
      rf_wdata_d    = late_result;
      q_push0_valid = early_ok;
      q_push0_entry = early_e;
    end else if (early_ok) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = early_rd;
      rf_wdata_d = early_result;
    end
  end

  // Late tag stage and registered register-file write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lv_q       <= 1'b0;
      lrd_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      lv_q       <= late_issue_valid;
      lrd_q      <= late_issue_rd;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi++) begin : g_qmatch
      assign qmatch_rs[gi] = q_entry_valid[gi] && (q_entry_rd[gi] == rs_addr);
      assign qmatch_rt[gi] = q_entry_valid[gi] && (q_entry_rd[gi] == rt_addr);
    end
  endgenerate

  // Hazards flag any uncommitted write to the source; forced low during reset
  // so live inputs cannot leak through while the block is held.
  always_comb begin
    hazard_rs = rst && (rs_addr != '0) &&
                ((|qmatch_rs) ||
                 (lv_q && (lrd_q == rs_addr)) ||
                 (early_valid && (early_rd == rs_addr)) ||
                 (late_issue_valid && (late_issue_rd == rs_addr)) ||
                 (rf_we_q && (rf_waddr_q == rs_addr)));
    hazard_rt = rst && (rt_addr != '0) &&
                ((|qmatch_rt) ||
                 (lv_q && (lrd_q == rt_addr)) ||
                 (early_valid && (early_rd == rt_addr)) ||
                 (late_issue_valid && (late_issue_rd == rt_addr)) ||
                 (rf_we_q && (rf_waddr_q == rt_addr)));
  end

  assign stall    = rst && (q_count >= CW'(2));
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // An arrival into a full queue means upstream ignored stall.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !((q_count == CW'(QDEPTH)) && (late_raw || early_raw)));

endmodule

// File: tb/tb_pipeline_late_wb.sv
// Directed bench for pipeline_late_wb: reset values, late/early ordering,
// r0 discard, stall-throttled bursts with queue wrap, and mid-run reset.
module tb_pipeline_late_wb;

  logic        clk;
  logic        rst;
  logic        late_issue_valid;
  logic [4:0]  late_issue_rd;
  logic [31:0] late_result;
  logic        early_valid;
  logic [4:0]  early_rd;
  logic [31:0] early_result;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        hazard_rs;
  logic        hazard_rt;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  pipeline_late_wb #(.QDEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .late_issue_valid (late_issue_valid),
    .late_issue_rd    (late_issue_rd),
    .late_result      (late_result),
    .early_valid      (early_valid),
    .early_rd         (early_rd),
    .early_result     (early_result),
    .rs_addr          (rs_addr),
    .rt_addr          (rt_addr),
    .hazard_rs        (hazard_rs),
    .hazard_rt        (hazard_rt),
    .stall            (stall),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    late_issue_valid = 1'b0;
    late_issue_rd    = '0;
    late_result      = '0;
    early_valid      = 1'b0;
    early_rd         = '0;
    early_result     = '0;
  endtask

  // Late ops rd 1,3,5 issued in cycles 0..2; cycles 1..3 each see a late
  // arrival plus an early arrival (rd 2,4,6). Data is base + rd, so writes
  // must emerge as rd 1..6 in cycles 2..7.
  task automatic burst(input logic [31:0] base, input int stop_k);
    int cnt_tab[9]   = '{0, 0, 1, 2, 3, 2, 1, 0, 0};
    int stall_tab[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic we_exp;
    for (int k = 0; k < stop_k; k++) begin
      late_issue_valid = (k <= 2);
      late_issue_rd    = 5'(2 * k + 1);
      if (k >= 1 && k <= 3) begin
        late_result  = base + 32'(2 * k - 1);
        early_valid  = 1'b1;
        early_rd     = 5'(2 * k);
        early_result = base + 32'(2 * k);
      end else begin
        late_result  = '0;
        early_valid  = 1'b0;
        early_rd     = '0;
        early_result = '0;
      end
      #3;
      check($sformatf("burst%h k%0d stall", base, k), 32'(stall), 32'(stall_tab[k]));
      check($sformatf("burst%h k%0d count", base, k), 32'(dut.q_count), 32'(cnt_tab[k]));
      we_exp = (k >= 2 && k <= 7);
      check($sformatf("burst%h k%0d rf_we", base, k), 32'(rf_we), 32'(we_exp));
      if (we_exp) begin
        check($sformatf("burst%h k%0d waddr", base, k), 32'(rf_waddr), 32'(k - 1));
        check($sformatf("burst%h k%0d wdata", base, k), rf_wdata, base + 32'(k - 1));
      end
      step();
    end
    idle();
  endtask

  initial begin
    // Reset with live inputs: everything must read as reset values.
    rst              = 1'b0;
    late_issue_valid = 1'b1;
    late_issue_rd    = 5'd7;
    late_result      = 32'h1234;
    early_valid      = 1'b1;
    early_rd         = 5'd7;
    early_result     = 32'h5678;
    rs_addr          = 5'd7;
    rt_addr          = 5'd7;
    #3;
    check("rst rf_we", 32'(rf_we), 32'd0);
    check("rst hazard_rs", 32'(hazard_rs), 32'd0);
    check("rst hazard_rt", 32'(hazard_rt), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    check("rst rf_we clk", 32'(rf_we), 32'd0);
    check("rst rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst rf_wdata", rf_wdata, 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst count", 32'(dut.q_count), 32'd0);
    idle();
    #2 rst = 1'b1;
    step();

    // Late op rd=5: hazard cycles 0-2, write visible cycle 2, gone cycle 3.
    rs_addr = 5'd5;
    rt_addr = 5'd6;
    late_issue_valid = 1'b1;
    late_issue_rd    = 5'd5;
    #3;
    check("late c0 hazard_rs", 32'(hazard_rs), 32'd1);
    check("late c0 hazard_rt", 32'(hazard_rt), 32'd0);
    step();
    late_issue_valid = 1'b0;
    late_issue_rd    = '0;
    late_result      = 32'h0000_00F0;
    #3;
    check("late c1 hazard_rs", 32'(hazard_rs), 32'd1);
    check("late c1 rf_we", 32'(rf_we), 32'd0);
    step();
    late_result = '0;
    #3;
    check("late c2 rf_we", 32'(rf_we), 32'd1);
    check("late c2 waddr", 32'(rf_waddr), 32'd5);
    check("late c2 wdata", rf_wdata, 32'hF0);
    check("late c2 hazard_rs", 32'(hazard_rs), 32'd1);
    step();
    #3;
    check("late c3 hazard_rs", 32'(hazard_rs), 32'd0);
    check("late c3 rf_we", 32'(rf_we), 32'd0);
    check("late c3 waddr held", 32'(rf_waddr), 32'd5);
    step();

    // Same-cycle late and early to r3: late (older) commits first.
    rs_addr = 5'd3;
    late_issue_valid = 1'b1;
    late_issue_rd    = 5'd3;
    step();
    late_issue_valid = 1'b0;
    late_result      = 32'hA;
    early_valid      = 1'b1;
    early_rd         = 5'd3;
    early_result     = 32'hB;
    #3;
    check("same c1 hazard_rs", 32'(hazard_rs), 32'd1);
    step();
    idle();
    #3;
    check("same c2 rf_we", 32'(rf_we), 32'd1);
    check("same c2 waddr", 32'(rf_waddr), 32'd3);
    check("same c2 wdata", rf_wdata, 32'hA);
    check("same c2 count", 32'(dut.q_count), 32'd1);
    check("same c2 hazard_rs", 32'(hazard_rs), 32'd1);
    step();
    #3;
    check("same c3 rf_we", 32'(rf_we), 32'd1);
    check("same c3 wdata", rf_wdata, 32'hB);
    check("same c3 count", 32'(dut.q_count), 32'd0);
    step();
    #3;
    check("same c4 rf_we", 32'(rf_we), 32'd0);
    check("same c4 wdata final", rf_wdata, 32'hB);
    step();

    // Early write to r0 is discarded and never raises a hazard.
    rs_addr      = 5'd0;
    rt_addr      = 5'd0;
    early_valid  = 1'b1;
    early_rd     = 5'd0;
    early_result = 32'hDEAD;
    #3;
    check("r0 hazard_rs", 32'(hazard_rs), 32'd0);
    check("r0 hazard_rt", 32'(hazard_rt), 32'd0);
    step();
    idle();
    #3;
    check("r0 rf_we", 32'(rf_we), 32'd0);
    check("r0 count", 32'(dut.q_count), 32'd0);
    check("r0 wdata held", rf_wdata, 32'hB);
    step();

    // Stall-throttled bursts; repeated bursts walk the pointers past the wrap.
    burst(32'h100, 9);
    burst(32'h200, 9);
    burst(32'h300, 9);

    // Reset asserted while three writes are queued and one is on the port.
    rs_addr = 5'd3;
    burst(32'h400, 4);
    early_valid = 1'b1;
    early_rd    = 5'd3;
    #3;
    check("midrst pre count", 32'(dut.q_count), 32'd3);
    check("midrst pre rf_we", 32'(rf_we), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst rf_we", 32'(rf_we), 32'd0);
    check("midrst waddr", 32'(rf_waddr), 32'd0);
    check("midrst wdata", rf_wdata, 32'd0);
    check("midrst stall", 32'(stall), 32'd0);
    check("midrst hazard_rs", 32'(hazard_rs), 32'd0);
    check("midrst count", 32'(dut.q_count), 32'd0);
    idle();
    step();
    #3 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      #3;
      check($sformatf("postrst c%0d rf_we", c), 32'(rf_we), 32'd0);
      check($sformatf("postrst c%0d count", c), 32'(dut.q_count), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipeline_late_wb.md
PIPELINE_LATE_WB -- requirements
Module: pipeline_late_wb

Interface
REQ-001 Parameter QDEPTH, default 4, number of write-queue entries (minimum 4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 late_issue_valid  input  1  late-ALU op (srl/sra) issued to the late ALU this cycle.
REQ-005 late_issue_rd  input  5  destination register of that late-ALU op.
REQ-006 late_result  input  32  registered late-ALU result; valid one cycle after the matching issue.
REQ-007 early_valid  input  1  early (single-cycle ALU/load) result valid this cycle.
REQ-008 early_rd  input  5  destination register of the early result.
REQ-009 early_result  input  32  early result data.
REQ-010 rs_addr, rt_addr  input  5 each  source registers of the instruction in decode.
REQ-011 hazard_rs, hazard_rt  output  1 each  source has a write not yet committed to the register file.
REQ-012 stall  output  1  upstream shall not issue any early or late op this cycle.
REQ-013 rf_we, rf_waddr, rf_wdata  output  1/5/32  registered register-file write port.

Function
REQ-014 The block registers late_issue_valid/late_issue_rd into a one-cycle tag stage (lv, lrd); in the next cycle, lv=1 pairs lrd with late_result as a "late arrival".
REQ-015 When lv=1 and early_valid=1 arrive in the same cycle, the late arrival is older and is ordered first.
REQ-016 Arrivals with rd=0 are discarded and never written or queued.
REQ-017 Each cycle, the candidates are taken oldest-first from the queue head, then the late arrival, then the early arrival; the oldest candidate loads {rf_we=1, rf_waddr, rf_wdata} at the clock edge, and the remaining candidates are enqueued in order.
REQ-018 With no candidate, rf_we=0 next cycle; rf_waddr/rf_wdata hold their previous values.
REQ-019 Minimum latency is arrival in cycle N to rf_we=1 in cycle N+1; a write is never reordered relative to older writes, so the last write wins for repeated rd.
REQ-020 The queue is a circular buffer with head/tail pointers wrapping modulo QDEPTH; count is 0..QDEPTH.
REQ-021 stall = (count >= 2), combinational from the registered count.
REQ-022 Under stall-obeying upstream traffic, count never exceeds 3; an arrival with count=QDEPTH is a protocol error, is dropped, and fires a simulation assertion.
REQ-023 hazard_rs=1 iff rs_addr!=0 and rs_addr matches any of: a valid queue entry, the tag stage (lv&&lrd), the current early arrival, the current late_issue_rd with late_issue_valid, or rf_waddr with rf_we=1. hazard_rt is defined identically for rt_addr.
REQ-024 Hazard outputs are combinational and carry no data; they do no forwarding.

Reset
REQ-025 While rst=0: rf_we=0, rf_waddr=0, rf_wdata=0, lv=0, lrd=0, head=tail=count=0, stall=0, and both hazards=0 for any address.
REQ-026 Reset asserted mid-operation discards all queued and in-flight writes with no partial write; the first rising clock edge after rst rises behaves as from empty.

Structure
REQ-027 Shared package holds the register-address width (5), data width (32), QDEPTH default, and the write-entry record {rd, data}.
REQ-028 One sub-module, pipeline_wb_queue: circular FIFO with 0/1/2 pushes and 0/1 pop per cycle, count output, and per-entry rd/valid visibility for hazard match.

Verification
REQ-029 late_issue rd=5 at cycle 0, late_result=0x0000_00F0 at cycle 1 -> rf_we=1, rf_waddr=5, rf_wdata=0xF0 at cycle 2; hazard_rs(rs=5)=1 in cycles 0-2 and 0 in cycle 3.
REQ-030 Same cycle: late rd=3 data 0xA plus early rd=3 data 0xB -> rf writes 3<-0xA, then 3<-0xB on consecutive cycles; the final value is 0xB.
REQ-031 Early rd=0 data 0xDEAD with no other traffic -> rf_we stays 0, count stays 0, and hazard on rs=0 is never set.
REQ-032 Two arrivals per cycle for 3 cycles while obeying stall -> stall rises when count reaches 2, count peaks at 3, all 6 writes emerge in order, and stall falls when count drops below 2.
REQ-033 Push of 3 entries, then pointer wrap over 2*QDEPTH writes -> output order is preserved across the wrap.
REQ-034 rst=0 asserted with count=3 and rf_we=1 -> all outputs go to their reset values immediately, without waiting for a clock, and no queued write appears after release.
